// File: rtl/jtag_axi_pkg.sv
// ============================================================================
// Module      : jtag_axi_pkg
// Description : Shared types, status codes and DR widths for the JTAG-to-AXI
//               bridge data registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_axi_pkg;

    typedef enum logic [3:0] {
        JTAG_IDLE       = 4'd0,
        JTAG_RUNNING    = 4'd1,
        JTAG_TIMEOUT_AW = 4'd2,
        JTAG_TIMEOUT_W  = 4'd3,
        JTAG_TIMEOUT_B  = 4'd4,
        JTAG_TIMEOUT_AR = 4'd5,
        JTAG_TIMEOUT_R  = 4'd6,
        JTAG_OKAY       = 4'd7,
        JTAG_SLVERR     = 4'd8,
        JTAG_DECERR     = 4'd9
    } jtag_status_e;

    typedef struct packed {
        logic [2:0] size;
        logic       txn_type;
        logic       start;
    } s_axi_jtag_ctrl_t;

    // ctrl sits at the LSB end so it is the first field shifted in/out
    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data_wr;
        s_axi_jtag_ctrl_t ctrl;
    } s_axi_jtag_info_t;

    typedef struct packed {
        jtag_status_e status;
        logic [31:0]  data_rd;
    } s_axi_jtag_status_t;

    typedef logic [3:0] axi_afifo_t;

    localparam int JTAG_INFO_DR_W   = $bits(s_axi_jtag_info_t);
    localparam int JTAG_STATUS_DR_W = $bits(axi_afifo_t) + $bits(s_axi_jtag_status_t);

    // A response may only be popped once the dispatch stage has a final result
    function automatic logic status_poppable(input jtag_status_e s);
        return !(s inside {JTAG_IDLE, JTAG_RUNNING, JTAG_TIMEOUT_AW, JTAG_TIMEOUT_W,
                           JTAG_TIMEOUT_B, JTAG_TIMEOUT_AR, JTAG_TIMEOUT_R});
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_dr_shift.sv
// ============================================================================
// Module      : jtag_dr_shift
// Description : Parameterised JTAG data register with capture/shift control
//               and a saturating shift-length counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_dr_shift #(
    parameter int W = 8
) (
    input  logic                     tck,
    input  logic                     trstn,
    input  logic                     sel,
    input  logic                     capture,
    input  logic                     shift,
    input  logic                     tdi,
    input  logic [W-1:0]             cap_data,
    output logic [W-1:0]             sr,
    output logic [$clog2(W+2)-1:0]   cnt
);

    localparam int CW = $clog2(W+2);
    localparam logic [CW-1:0] CNT_MAX = CW'(W + 1);

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            sr  <= '0;
            cnt <= '0;
        end else if (sel) begin
            if (capture) begin
                sr  <= cap_data;
                cnt <= '0;
            end else if (shift) begin
                sr <= {tdi, sr[W-1:1]};
                // W+1 is enough to tell "exact" from "too long"
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtag_axi_dr_regs.sv
// ============================================================================
// Module      : jtag_axi_dr_regs
// Description : AXI_INFO / AXI_STATUS JTAG data registers with request commit,
//               response pop and shift-length error tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_axi_dr_regs
    import jtag_axi_pkg::*;
#(
    parameter int INFO_DR_W   = $bits(s_axi_jtag_info_t),
    parameter int STATUS_DR_W = $bits(axi_afifo_t) + $bits(s_axi_jtag_status_t)
) (
    input  logic               tck,
    input  logic               trstn,
    input  logic               tdi,
    output logic               tdo_o,
    input  logic               capture_dr_i,
    input  logic               shift_dr_i,
    input  logic               update_dr_i,
    input  logic               sel_info_i,
    input  logic               sel_status_i,
    output s_axi_jtag_info_t   axi_info_o,
    output logic               axi_req_new_o,
    output logic               axi_status_rd_o,
    input  s_axi_jtag_status_t jtag_status_i,
    input  axi_afifo_t         afifo_slots_i,
    output logic               dr_err_o
);

    localparam int ICW = $clog2(INFO_DR_W + 2);
    localparam int SCW = $clog2(STATUS_DR_W + 2);
    localparam logic [ICW-1:0] INFO_LEN   = ICW'(INFO_DR_W);
    localparam logic [SCW-1:0] STATUS_LEN = SCW'(STATUS_DR_W);

    logic [INFO_DR_W-1:0]   info_sr;
    logic [STATUS_DR_W-1:0] status_sr;
    logic [ICW-1:0]         info_cnt;
    logic [SCW-1:0]         status_cnt;
    s_axi_jtag_info_t       info_q;
    jtag_status_e           cap_status;
    logic                   bypass;
    logic                   no_sel;

    assign no_sel = !sel_info_i && !sel_status_i;
    assign info_q = info_sr;

    jtag_dr_shift #(.W(INFO_DR_W)) u_info_dr (
        .tck      (tck),
        .trstn    (trstn),
        .sel      (sel_info_i),
        .capture  (capture_dr_i),
        .shift    (shift_dr_i),
        .tdi      (tdi),
        .cap_data (INFO_DR_W'(axi_info_o)),
        .sr       (info_sr),
        .cnt      (info_cnt)
    );

    jtag_dr_shift #(.W(STATUS_DR_W)) u_status_dr (
        .tck      (tck),
        .trstn    (trstn),
        .sel      (sel_status_i),
        .capture  (capture_dr_i),
        .shift    (shift_dr_i),
        .tdi      (tdi),
        .cap_data (STATUS_DR_W'({afifo_slots_i, jtag_status_i.status, jtag_status_i.data_rd})),
        .sr       (status_sr),
        .cnt      (status_cnt)
    );

    always_comb begin
        tdo_o = bypass;
        if (sel_info_i) begin
            tdo_o = info_sr[0];
        end else if (sel_status_i) begin
            tdo_o = status_sr[0];
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            axi_info_o      <= '0;
            axi_req_new_o   <= 1'b0;
            axi_status_rd_o <= 1'b0;
            dr_err_o        <= 1'b0;
            cap_status      <= JTAG_IDLE;
            bypass          <= 1'b0;
        end else begin
            axi_req_new_o   <= 1'b0;
            axi_status_rd_o <= 1'b0;

            // start=1 image is visible only during the request pulse
            if (axi_req_new_o) begin
                axi_info_o.ctrl.start <= 1'b0;
            end

            if (capture_dr_i) begin
                if (no_sel) begin
                    bypass <= 1'b0;
                end
                if (sel_status_i) begin
                    cap_status <= jtag_status_i.status;
                end
                if (sel_info_i && !axi_info_o.ctrl.start) begin
                    dr_err_o <= 1'b0;
                end
            end

            if (shift_dr_i && no_sel) begin
                bypass <= tdi;
            end

            if (update_dr_i && sel_info_i) begin
                if (info_cnt == INFO_LEN) begin
                    axi_info_o    <= info_q;
                    axi_req_new_o <= info_q.ctrl.start;
                end else begin
                    dr_err_o <= 1'b1;
                end
            end

            if (update_dr_i && sel_status_i) begin
                if (status_cnt >= STATUS_LEN) begin
                    axi_status_rd_o <= status_poppable(cap_status);
                end else begin
                    dr_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtag_axi_dr_regs.sv
// ============================================================================
// Module      : tb_jtag_axi_dr_regs
// Description : Directed self-checking bench for jtag_axi_dr_regs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_axi_dr_regs;
    import jtag_axi_pkg::*;

    localparam int IW = $bits(s_axi_jtag_info_t);
    localparam int SW = $bits(axi_afifo_t) + $bits(s_axi_jtag_status_t);

    logic               tck = 1'b0;
    logic               trstn;
    logic               tdi;
    logic               tdo_o;
    logic               capture_dr_i;
    logic               shift_dr_i;
    logic               update_dr_i;
    logic               sel_info_i;
    logic               sel_status_i;
    s_axi_jtag_info_t   axi_info_o;
    logic               axi_req_new_o;
    logic               axi_status_rd_o;
    s_axi_jtag_status_t jtag_status_i;
    axi_afifo_t         afifo_slots_i;
    logic               dr_err_o;

    int checks   = 0;
    int failures = 0;
    int req_pulses = 0;
    int rd_pulses  = 0;

    s_axi_jtag_info_t img_a;

    jtag_axi_dr_regs dut (
        .tck             (tck),
        .trstn           (trstn),
        .tdi             (tdi),
        .tdo_o           (tdo_o),
        .capture_dr_i    (capture_dr_i),
        .shift_dr_i      (shift_dr_i),
        .update_dr_i     (update_dr_i),
        .sel_info_i      (sel_info_i),
        .sel_status_i    (sel_status_i),
        .axi_info_o      (axi_info_o),
        .axi_req_new_o   (axi_req_new_o),
        .axi_status_rd_o (axi_status_rd_o),
        .jtag_status_i   (jtag_status_i),
        .afifo_slots_i   (afifo_slots_i),
        .dr_err_o        (dr_err_o)
    );

    always #5 tck = ~tck;

    always @(negedge tck) begin
        if (axi_req_new_o === 1'b1) req_pulses++;
        if (axi_status_rd_o === 1'b1) rd_pulses++;
    end

    task automatic do_capture();
        capture_dr_i = 1'b1;
        @(negedge tck);
        capture_dr_i = 1'b0;
    endtask

    task automatic do_shift(input logic [127:0] d, input int n, output logic [127:0] q);
        q = '0;
        for (int i = 0; i < n; i++) begin
            tdi        = d[i];
            shift_dr_i = 1'b1;
            q[i]       = tdo_o;
            @(negedge tck);
        end
        shift_dr_i = 1'b0;
        tdi        = 1'b0;
    endtask

    task automatic do_update();
        update_dr_i = 1'b1;
        @(negedge tck);
        update_dr_i = 1'b0;
    endtask

    task automatic test_reset();
        trstn = 1'b0;
        repeat (2) @(negedge tck);
        checks++; if (axi_info_o !== '0) begin failures++; $display("FAIL reset_info got=%h exp=0", axi_info_o); end
        checks++; if (axi_req_new_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", axi_req_new_o); end
        checks++; if (axi_status_rd_o !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", axi_status_rd_o); end
        checks++; if (dr_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", dr_err_o); end
        checks++; if (tdo_o !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b exp=0", tdo_o); end
        trstn = 1'b1;
        @(negedge tck);
    endtask

    task automatic test_info_write();
        logic [127:0] q;
        int p0;
        img_a.addr          = 32'h4000_0000;
        img_a.data_wr       = 32'h1234_5678;
        img_a.ctrl.size     = 3'd2;
        img_a.ctrl.txn_type = 1'b0;
        img_a.ctrl.start    = 1'b1;
        p0 = req_pulses;
        sel_info_i = 1'b1;
        do_capture();
        do_shift(128'(img_a), IW, q);
        do_update();
        checks++; if (axi_req_new_o !== 1'b1) begin failures++; $display("FAIL info_req_pulse got=%b exp=1", axi_req_new_o); end
        checks++; if (axi_info_o !== img_a) begin failures++; $display("FAIL info_start_image got=%h exp=%h", axi_info_o, img_a); end
        @(negedge tck);
        img_a.ctrl.start = 1'b0;
        checks++; if (axi_req_new_o !== 1'b0) begin failures++; $display("FAIL info_req_end got=%b exp=0", axi_req_new_o); end
        checks++; if (axi_info_o !== img_a) begin failures++; $display("FAIL info_stored got=%h exp=%h", axi_info_o, img_a); end
        checks++; if (axi_info_o.addr !== 32'h4000_0000) begin failures++; $display("FAIL info_addr got=%h exp=40000000", axi_info_o.addr); end
        checks++; if (req_pulses - p0 !== 1) begin failures++; $display("FAIL info_pulse_count got=%0d exp=1", req_pulses - p0); end
        checks++; if (dr_err_o !== 1'b0) begin failures++; $display("FAIL info_err got=%b exp=0", dr_err_o); end
        sel_info_i = 1'b0;
    endtask

    task automatic test_short_shift();
        logic [127:0] q;
        s_axi_jtag_info_t bad;
        int p0;
        bad.addr    = 32'h5555_AAAA;
        bad.data_wr = 32'hCAFE_0001;
        bad.ctrl    = 5'b00011;
        p0 = req_pulses;
        sel_info_i = 1'b1;
        do_capture();
        do_shift(128'(bad), IW - 1, q);
        do_update();
        @(negedge tck);
        checks++; if (axi_info_o !== img_a) begin failures++; $display("FAIL short_info got=%h exp=%h", axi_info_o, img_a); end
        checks++; if (req_pulses - p0 !== 0) begin failures++; $display("FAIL short_pulse got=%0d exp=0", req_pulses - p0); end
        checks++; if (dr_err_o !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", dr_err_o); end
        sel_info_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] q;
        s_axi_jtag_info_t a, b;
        int p0;
        a = img_a; a.addr = 32'h4000_0010; a.ctrl.start = 1'b1;
        b = img_a; b.addr = 32'h4000_0020; b.ctrl.start = 1'b1; b.ctrl.txn_type = 1'b1;
        p0 = req_pulses;
        sel_info_i = 1'b1;
        do_capture();
        checks++; if (dr_err_o !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", dr_err_o); end
        do_shift(128'(a), IW, q);
        do_update();
        do_capture();
        do_shift(128'(b), IW, q);
        do_update();
        @(negedge tck);
        b.ctrl.start = 1'b0;
        checks++; if (req_pulses - p0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", req_pulses - p0); end
        checks++; if (axi_info_o !== b) begin failures++; $display("FAIL b2b_info got=%h exp=%h", axi_info_o, b); end
        sel_info_i = 1'b0;
    endtask

    task automatic test_status_okay();
        logic [127:0] q;
        logic [SW-1:0] exp;
        int p0;
        jtag_status_i.status  = JTAG_OKAY;
        jtag_status_i.data_rd = 32'hDEAD_BEEF;
        afifo_slots_i         = 4'h3;
        exp = {4'h3, 4'd7, 32'hDEAD_BEEF};
        p0 = rd_pulses;
        sel_status_i = 1'b1;
        do_capture();
        jtag_status_i = '0;
        do_shift(128'(0), SW, q);
        checks++; if (q[SW-1:0] !== exp) begin failures++; $display("FAIL status_stream got=%h exp=%h", q[SW-1:0], exp); end
        do_update();
        checks++; if (axi_status_rd_o !== 1'b1) begin failures++; $display("FAIL status_pop got=%b exp=1", axi_status_rd_o); end
        @(negedge tck);
        checks++; if (axi_status_rd_o !== 1'b0) begin failures++; $display("FAIL status_pop_end got=%b exp=0", axi_status_rd_o); end
        checks++; if (rd_pulses - p0 !== 1) begin failures++; $display("FAIL status_pop_count got=%0d exp=1", rd_pulses - p0); end
        sel_status_i = 1'b0;
    endtask

    task automatic test_status_lengths();
        logic [127:0] q;
        int p0;
        sel_status_i = 1'b1;
        jtag_status_i.status  = JTAG_SLVERR;
        jtag_status_i.data_rd = 32'h0BAD_F00D;
        p0 = rd_pulses;
        do_capture();
        do_shift(128'(0), SW + 5, q);
        do_update();
        @(negedge tck);
        checks++; if (rd_pulses - p0 !== 1) begin failures++; $display("FAIL status_long_pop got=%0d exp=1", rd_pulses - p0); end
        jtag_status_i.status = JTAG_OKAY;
        p0 = rd_pulses;
        do_capture();
        do_shift(128'(0), SW - 1, q);
        do_update();
        @(negedge tck);
        checks++; if (rd_pulses - p0 !== 0) begin failures++; $display("FAIL status_short_pop got=%0d exp=0", rd_pulses - p0); end
        checks++; if (dr_err_o !== 1'b1) begin failures++; $display("FAIL status_short_err got=%b exp=1", dr_err_o); end
        sel_status_i = 1'b0;
    endtask

    task automatic test_status_not_ready();
        logic [127:0] q;
        jtag_status_e codes [2];
        int p0;
        codes[0] = JTAG_RUNNING;
        codes[1] = JTAG_TIMEOUT_R;
        sel_status_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            jtag_status_i.status  = codes[k];
            jtag_status_i.data_rd = 32'h1111_2222;
            p0 = rd_pulses;
            do_capture();
            do_shift(128'(0), SW, q);
            do_update();
            @(negedge tck);
            checks++; if (rd_pulses - p0 !== 0) begin failures++; $display("FAIL status_not_ready code=%0d got=%0d exp=0", codes[k], rd_pulses - p0); end
        end
        sel_status_i = 1'b0;
    endtask

    task automatic test_bypass();
        logic [3:0] pat;
        logic [127:0] q;
        s_axi_jtag_info_t info0;
        int p0, r0;
        pat = 4'b1101;
        info0 = axi_info_o;
        p0 = req_pulses;
        r0 = rd_pulses;
        do_capture();
        checks++; if (tdo_o !== 1'b0) begin failures++; $display("FAIL bypass_cap got=%b exp=0", tdo_o); end
        for (int i = 0; i < 4; i++) begin
            tdi = pat[i];
            shift_dr_i = 1'b1;
            @(negedge tck);
            checks++; if (tdo_o !== pat[i]) begin failures++; $display("FAIL bypass_bit%0d got=%b exp=%b", i, tdo_o, pat[i]); end
        end
        shift_dr_i = 1'b0;
        do_update();
        @(negedge tck);
        checks++; if (axi_info_o !== info0) begin failures++; $display("FAIL bypass_info got=%h exp=%h", axi_info_o, info0); end
        checks++; if (dr_err_o !== 1'b1) begin failures++; $display("FAIL bypass_err got=%b exp=1", dr_err_o); end
        checks++; if ((req_pulses - p0) + (rd_pulses - r0) !== 0) begin failures++; $display("FAIL bypass_pulses got=%0d exp=0", (req_pulses - p0) + (rd_pulses - r0)); end
        q = '0;
    endtask

    task automatic test_reset_mid_shift();
        logic [127:0] q;
        s_axi_jtag_info_t c;
        int p0;
        c = img_a; c.addr = 32'h7777_0000; c.ctrl.start = 1'b1;
        sel_info_i = 1'b1;
        do_capture();
        do_shift(128'(c), 10, q);
        #2 trstn = 1'b0;
        #1;
        checks++; if (axi_info_o !== '0) begin failures++; $display("FAIL rst_mid_info got=%h exp=0", axi_info_o); end
        checks++; if ({axi_req_new_o, axi_status_rd_o, dr_err_o, tdo_o} !== 4'b0) begin failures++; $display("FAIL rst_mid_outs got=%b exp=0000", {axi_req_new_o, axi_status_rd_o, dr_err_o, tdo_o}); end
        @(negedge tck);
        trstn = 1'b1;
        @(negedge tck);
        p0 = req_pulses;
        do_update();
        @(negedge tck);
        checks++; if (req_pulses - p0 !== 0) begin failures++; $display("FAIL rst_mid_pulse got=%0d exp=0", req_pulses - p0); end
        checks++; if (dr_err_o !== 1'b1) begin failures++; $display("FAIL rst_mid_err got=%b exp=1", dr_err_o); end
        checks++; if (axi_info_o !== '0) begin failures++; $display("FAIL rst_mid_info_after got=%h exp=0", axi_info_o); end
        sel_info_i = 1'b0;
    endtask

    initial begin
        trstn         = 1'b0;
        tdi           = 1'b0;
        capture_dr_i  = 1'b0;
        shift_dr_i    = 1'b0;
        update_dr_i   = 1'b0;
        sel_info_i    = 1'b0;
        sel_status_i  = 1'b0;
        jtag_status_i = '0;
        afifo_slots_i = '0;
        img_a         = '0;
        @(negedge tck);
        test_reset();
        test_info_write();
        test_short_shift();
        test_back_to_back();
        test_status_okay();
        test_status_lengths();
        test_status_not_ready();
        test_bypass();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
